// File: rtl/energy_pkg.sv
// Shared constants and FSM state encoding for the energy accumulator slice.
package energy_pkg;

  localparam int OPER_W    = 4;
  localparam int PROD_W    = 8;
  localparam int ACC_W_DEF = 12;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_e;

endpackage

// File: rtl/Multiplier_4.sv
// 4x4 unsigned combinational multiplier shared across the SmartHomeSystem blocks.
module Multiplier_4 (
  input  logic [3:0] I1,
  input  logic [3:0] I2,
  output logic [7:0] P
);

  assign P = 8'(I1) * 8'(I2);

endmodule

// File: rtl/energy_accumulator.sv
// Handshaked front/back stage around Multiplier_4 that accumulates energy products.
// Build option: ENERGY_SATURATE_EN clamps the total on overflow instead of wrapping.
module energy_accumulator
  import energy_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       rate,
  input  logic [3:0]       duration,
  input  logic             clear,
  output logic [ACC_W-1:0] total,
  output logic [CNT_W-1:0] count,
  output logic             upd,
  output logic             ovf
);

  state_e              state_q, state_d;
  logic [OPER_W-1:0]   op_a_q, op_a_d;
  logic [OPER_W-1:0]   op_b_q, op_b_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [PROD_W-1:0]   product;
  logic [ACC_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                upd_q, upd_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic [ACC_W:0]      sum;

  Multiplier_4 u_mult (
    .I1 (op_a_q),
    .I2 (op_b_q),
    .P  (product)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    prod_d  = prod_q;
    total_d = total_q;
    count_d = count_q;
    upd_d   = 1'b0;
    ovf_d   = ovf_q;
    sum     = {1'b0, total_q} + (ACC_W+1)'(prod_q);

    if (clear) begin
      // Clear wins over everything, including a handshake offered this cycle.
      state_d = IDLE;
      total_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_a_d  = rate;
            op_b_d  = duration;
            state_d = MUL;
          end
        end
        MUL: begin
          prod_d  = product;
          state_d = ACC;
        end
        ACC: begin
          count_d = count_q + CNT_W'(1);
          upd_d   = 1'b1;
          state_d = IDLE;
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef ENERGY_SATURATE_EN
            total_d = '1;
`else
            total_d = sum[ACC_W-1:0];
`endif
          end else begin
            total_d = sum[ACC_W-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      prod_q     <= '0;
      total_q    <= '0;
      count_q    <= '0;
      upd_q      <= 1'b0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      prod_q     <= prod_d;
      total_q    <= total_d;
      count_q    <= count_d;
      upd_q      <= upd_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign total    = total_q;
  assign count    = count_q;
  assign upd      = upd_q;
  assign ovf      = ovf_q;

endmodule
